// File: rtl/cpu_trace_serializer.sv
// rtl/cpu_trace_serializer.sv - write-back trace record to one-char-per-clock ASCII line
// Line: "^<time>@<pc>: $<reg> <= <data>#" or "^<time>@<pc>: *<addr> <= <data>#".
module cpu_trace_serializer #(
  parameter int PAD_COLON      = 1,
  parameter int PAD_PRE_ARROW  = 1,
  parameter int PAD_POST_ARROW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CARET = 4'd1;
  localparam logic [3:0] S_TIME  = 4'd2;
  localparam logic [3:0] S_AT    = 4'd3;
  localparam logic [3:0] S_PC    = 4'd4;
  localparam logic [3:0] S_COLON = 4'd5;
  localparam logic [3:0] S_PAD1  = 4'd6;
  localparam logic [3:0] S_TAG   = 4'd7;
  localparam logic [3:0] S_IDX   = 4'd8;
  localparam logic [3:0] S_PAD2  = 4'd9;
  localparam logic [3:0] S_LT    = 4'd10;
  localparam logic [3:0] S_EQ    = 4'd11;
  localparam logic [3:0] S_PAD3  = 4'd12;
  localparam logic [3:0] S_DATA  = 4'd13;
  localparam logic [3:0] S_HASH  = 4'd14;

  logic [3:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_mem_q, is_mem_d;
  logic [15:0] tbcd_q, tbcd_d;
  logic [2:0]  tdig_q, tdig_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] idx_q, idx_d;
  logic [3:0]  idx_dig_q, idx_dig_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  char_q, char_d;
  logic [13:0] t_sat;
  logic [3:0]  len;
  logic [2:0]  tpos;
  logic [3:0]  rpos;
  logic        accept;

  function automatic logic [7:0] hex_nib(input logic [31:0] v, input logic [5:0] sh);
    logic [3:0] n;
    n = 4'(v >> sh);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Zero-width pad fields are bypassed here so they cost no cycles.
  function automatic logic [3:0] next_of(input logic [3:0] s);
    case (s)
      S_CARET: return S_TIME;
      S_TIME:  return S_AT;
      S_AT:    return S_PC;
      S_PC:    return S_COLON;
      S_COLON: return (PAD_COLON > 0) ? S_PAD1 : S_TAG;
      S_PAD1:  return S_TAG;
      S_TAG:   return S_IDX;
      S_IDX:   return (PAD_PRE_ARROW > 0) ? S_PAD2 : S_LT;
      S_PAD2:  return S_LT;
      S_LT:    return S_EQ;
      S_EQ:    return (PAD_POST_ARROW > 0) ? S_PAD3 : S_DATA;
      S_PAD3:  return S_DATA;
      S_DATA:  return S_HASH;
      default: return S_IDLE;
    endcase
  endfunction

  assign accept     = in_valid && in_ready;
  assign in_ready   = (state_q == S_IDLE) || (state_q == S_HASH);
  assign char_valid = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign char       = char_q;

  always_comb begin
    case (state_q)
      S_TIME:  len = {1'b0, tdig_q};
      S_PC:    len = 4'd8;
      S_PAD1:  len = 4'(PAD_COLON);
      S_IDX:   len = idx_dig_q;
      S_PAD2:  len = 4'(PAD_PRE_ARROW);
      S_PAD3:  len = 4'(PAD_POST_ARROW);
      S_DATA:  len = 4'd8;
      default: len = 4'd1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mem_d  = is_mem_q;
    tbcd_d    = tbcd_q;
    tdig_d    = tdig_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    idx_dig_d = idx_dig_q;
    data_d    = data_q;
    t_sat     = (in_time > 14'd9999) ? 14'd9999 : in_time;

    case (state_q)
      S_IDLE: ;
      S_HASH: state_d = S_IDLE;
      default: begin
        if ({1'b0, cnt_q} == len - 4'd1) begin
          cnt_d   = 3'd0;
          state_d = next_of(state_q);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
    endcase

    // BCD is formed while latching so TIME digits are ready one cycle later.
    if (accept) begin
      cnt_d    = 3'd0;
      state_d  = (in_kind == 2'd1 || in_kind == 2'd2) ? S_CARET : S_IDLE;
      is_mem_d = (in_kind == 2'd2);
      tbcd_d   = {4'(t_sat / 14'd1000), 4'((t_sat / 14'd100) % 14'd10),
                  4'((t_sat / 14'd10) % 14'd10), 4'(t_sat % 14'd10)};
      tdig_d   = (t_sat >= 14'd1000) ? 3'd4 : (t_sat >= 14'd100) ? 3'd3 :
                 (t_sat >= 14'd10) ? 3'd2 : 3'd1;
      pc_d     = in_pc;
      data_d   = in_data;
      if (in_kind == 2'd2) begin
        idx_d     = in_addr;
        idx_dig_d = 4'd8;
      end else begin
        idx_d     = {24'd0, 4'(in_reg / 5'd10), 4'(in_reg % 5'd10)};
        idx_dig_d = (in_reg >= 5'd10) ? 4'd2 : 4'd1;
      end
    end
  end

  always_comb begin
    tpos = tdig_q - 3'd1 - cnt_d;
    rpos = idx_dig_q - 4'd1 - {1'b0, cnt_d};
    case (state_d)
      S_CARET: char_d = 8'h5e;
      S_TIME:  char_d = hex_nib({16'd0, tbcd_q}, {1'b0, tpos, 2'b00});
      S_AT:    char_d = 8'h40;
      S_PC:    char_d = hex_nib(pc_q, {1'b0, 3'd7 - cnt_d, 2'b00});
      S_COLON: char_d = 8'h3a;
      S_PAD1, S_PAD2, S_PAD3: char_d = 8'h20;
      S_TAG:   char_d = is_mem_q ? 8'h2a : 8'h24;
      S_IDX:   char_d = is_mem_q ? hex_nib(idx_q, {1'b0, 3'd7 - cnt_d, 2'b00})
                                 : hex_nib(idx_q, {rpos, 2'b00});
      S_LT:    char_d = 8'h3c;
      S_EQ:    char_d = 8'h3d;
      S_DATA:  char_d = hex_nib(data_q, {1'b0, 3'd7 - cnt_d, 2'b00});
      S_HASH:  char_d = 8'h23;
      default: char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      is_mem_q  <= 1'b0;
      tbcd_q    <= 16'd0;
      tdig_q    <= 3'd1;
      pc_q      <= 32'd0;
      idx_q     <= 32'd0;
      idx_dig_q <= 4'd1;
      data_q    <= 32'd0;
      char_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mem_q  <= is_mem_d;
      tbcd_q    <= tbcd_d;
      tdig_q    <= tdig_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      idx_dig_q <= idx_dig_d;
      data_q    <= data_d;
      char_q    <= char_d;
    end
  end

endmodule
